// File: rtl/thermal_pkg.sv
// Shared types, constants and helpers for the thermal sensor conditioning path.
package thermal_pkg;

    typedef enum logic [1:0] {FILL, RUN, STALE} thermal_state_e;

    localparam int unsigned TEMP_FRAC_BITS = 4;
    localparam int unsigned CAL_CODE_W     = 12;

    function automatic logic [7:0] sat_u8(input logic signed [15:0] v);
        if (v < 16'sd0) begin
            return 8'd0;
        end else if (v > 16'sd255) begin
            return 8'd255;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/thermal_mavg.sv
// Moving-average accumulator: circular tap buffer, running sum and fill count.
module thermal_mavg
    import thermal_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_TAPS),
    localparam int unsigned SUM_W   = CAL_CODE_W + IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [CAL_CODE_W-1:0] data_i,
    output logic [SUM_W-1:0]      sum_o,
    output logic                  fill_last_o
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TAPS - 1);

    logic [CAL_CODE_W-1:0] taps_q [NUM_TAPS];
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      count_q;
    logic                  full;

    assign full        = (count_q == FULL_CNT);
    assign fill_last_o = (count_q == LAST_CNT);
    assign sum_o       = sum_q;

    // While filling, the slot being overwritten holds no counted sample.
    always_comb begin
        sum_d = sum_q + SUM_W'(data_i);
        if (full) begin
            sum_d = sum_d - SUM_W'(taps_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            sum_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else if (push_i) begin
            sum_q <= sum_d;
            idx_q <= idx_q + 1'b1;
            if (!full) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            taps_q[idx_q] <= data_i;
        end
    end

endmodule

// File: rtl/thermal_sensor_conditioner.sv
// Calibrates, filters and supervises on-die thermal sensor samples for the power manager.
module thermal_sensor_conditioner
    import thermal_pkg::*;
#(
    parameter int unsigned NUM_TAPS       = 8,
    parameter int unsigned STALE_CYCLES   = 4096,
    parameter int unsigned DEFAULT_TEMP_C = 85
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [11:0] sample_code,
    input  logic [15:0] cal_gain_q8,
    input  logic [15:0] cal_offset_x16,
    input  logic [7:0]  alarm_hi_c,
    input  logic [7:0]  alarm_lo_c,
    output logic [7:0]  temperature,
    output logic        temp_valid,
    output logic        over_temp,
    output logic        sensor_stale
);

    localparam int unsigned IDX_W  = $clog2(NUM_TAPS);
    localparam int unsigned SUM_W  = CAL_CODE_W + IDX_W;
    localparam int unsigned AVG_W  = CAL_CODE_W - TEMP_FRAC_BITS + 1;
    localparam int unsigned IDLE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALE_CYCLES);
    localparam logic [7:0]        DEF_TEMP = 8'(DEFAULT_TEMP_C);

    thermal_state_e        state_q;
    logic [IDLE_W-1:0]     idle_q;
    logic                  ready_q, valid_q, over_q, stale_q;
    logic [7:0]            temp_q;

    logic                  s0_valid_q, s1_valid_q;
    logic [11:0]           s0_code_q;
    logic [15:0]           s0_gain_q, s0_off_q;
    logic [CAL_CODE_W-1:0] s1_cal_q, cal_clamped;
    logic signed [21:0]    cal_raw;

    logic [SUM_W-1:0]      sum;
    logic                  fill_last;
    logic [AVG_W-1:0]      avg;
    logic [7:0]            avg_c;
    logic                  accept, go_stale;

    assign accept   = sample_valid && ready_q;
    assign go_stale = (state_q != STALE) && !accept && (idle_q == IDLE_MAX);

    always_comb begin
        cal_raw = $signed({2'b00, 20'((28'(s0_code_q) * 28'(s0_gain_q)) >> 8)})
                + $signed({{6{s0_off_q[15]}}, s0_off_q});
        if (cal_raw[21]) begin
            cal_clamped = '0;
        end else if (cal_raw > 22'sd4095) begin
            cal_clamped = '1;
        end else begin
            cal_clamped = cal_raw[CAL_CODE_W-1:0];
        end
    end

    // Round half up: add half an LSB of the output before dividing by taps * 16.
    assign avg   = AVG_W'(({1'b0, sum} + (SUM_W + 1)'(NUM_TAPS * 8)) >> (IDX_W + TEMP_FRAC_BITS));
    assign avg_c = sat_u8($signed(16'(avg)));

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_code_q  <= '0;
            s0_gain_q  <= '0;
            s0_off_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_cal_q   <= '0;
        end else begin
            s0_valid_q <= accept;
            if (accept) begin
                s0_code_q <= sample_code;
                s0_gain_q <= cal_gain_q8;
                s0_off_q  <= cal_offset_x16;
            end
            s1_valid_q <= s0_valid_q;
            s1_cal_q   <= cal_clamped;
        end
    end

    thermal_mavg #(
        .NUM_TAPS (NUM_TAPS)
    ) u_mavg (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (go_stale),
        .push_i      (s1_valid_q),
        .data_i      (s1_cal_q),
        .sum_o       (sum),
        .fill_last_o (fill_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            idle_q  <= '0;
            ready_q <= 1'b0;
            temp_q  <= DEF_TEMP;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                idle_q <= '0;
            end else if (idle_q != IDLE_MAX) begin
                idle_q <= idle_q + 1'b1;
            end

            unique case (state_q)
                FILL:    if (go_stale) state_q <= STALE;
                         else if (s1_valid_q && fill_last) state_q <= RUN;
                RUN:     if (go_stale) state_q <= STALE;
                STALE:   if (accept) state_q <= FILL;
                default: state_q <= FILL;
            endcase

            if (go_stale || state_q == STALE) begin
                temp_q  <= DEF_TEMP;
                valid_q <= 1'b0;
                over_q  <= 1'b1;
                stale_q <= 1'b1;
            end else if (state_q == RUN) begin
                temp_q  <= avg_c;
                valid_q <= 1'b1;
                stale_q <= 1'b0;
                if (avg_c >= alarm_hi_c) begin
                    over_q <= 1'b1;
                end else if (avg_c <= alarm_lo_c) begin
                    over_q <= 1'b0;
                end
            end else begin
                temp_q  <= DEF_TEMP;
                valid_q <= 1'b0;
                stale_q <= 1'b0;
            end
        end
    end

    assign sample_ready = ready_q;
    assign temperature  = temp_q;
    assign temp_valid   = valid_q;
    assign over_temp    = over_q;
    assign sensor_stale = stale_q;

endmodule

// File: tb/tb_thermal_sensor_conditioner.sv
// Scoreboard bench: a reference model predicts each accepted sample's outputs three edges later.
module tb_thermal_sensor_conditioner;

    localparam int N   = 8;
    localparam int DEF = 85;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [11:0] sample_code = '0;
    logic [15:0] cal_gain_q8 = 16'd256;
    logic [15:0] cal_offset_x16 = 16'd0;
    logic [7:0]  alarm_hi_c = 8'd200;
    logic [7:0]  alarm_lo_c = 8'd190;
    logic [7:0]  temperature;
    logic        temp_valid, over_temp, sensor_stale;

    always #5 clk = ~clk;

    thermal_sensor_conditioner #(
        .NUM_TAPS       (N),
        .STALE_CYCLES   (4096),
        .DEFAULT_TEMP_C (DEF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_code    (sample_code),
        .cal_gain_q8    (cal_gain_q8),
        .cal_offset_x16 (cal_offset_x16),
        .alarm_hi_c     (alarm_hi_c),
        .alarm_lo_c     (alarm_lo_c),
        .temperature    (temperature),
        .temp_valid     (temp_valid),
        .over_temp      (over_temp),
        .sensor_stale   (sensor_stale)
    );

    typedef struct {
        int due;
        int temp;
        int valid;
        int over;
    } exp_t;

    exp_t sb[$];
    int   win[$];
    int   m_over = 0;
    int   edge_n = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_cal(input int code, input int gain, input int off);
        int v;
        v = (code * gain) / 256 + off;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        return v;
    endfunction

    task automatic model_accept();
        int   cal, sum, t;
        exp_t e;
        cal = model_cal(int'(sample_code), int'(cal_gain_q8), int'($signed(cal_offset_x16)));
        win.push_back(cal);
        if (win.size() > N) void'(win.pop_front());
        e.due = edge_n + 3;
        if (win.size() == N) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            t = (sum + N * 8) / (N * 16);
            if (t > 255) t = 255;
            if (t >= int'(alarm_hi_c)) m_over = 1;
            else if (t <= int'(alarm_lo_c)) m_over = 0;
            e.temp  = t;
            e.valid = 1;
        end else begin
            e.temp  = DEF;
            e.valid = 0;
        end
        e.over = m_over;
        sb.push_back(e);
    endtask

    // Called at a negedge; advances one clock and checks any result due at this edge.
    task automatic step();
        logic acc;
        exp_t e;
        acc = sample_valid && sample_ready;
        @(posedge clk);
        edge_n++;
        if (acc) model_accept();
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            e = sb.pop_front();
            check_eq("sb_temp", temperature, e.temp);
            check_eq("sb_valid", temp_valid, e.valid);
            check_eq("sb_over", over_temp, e.over);
        end
    endtask

    task automatic burst(input int code, input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_code  = 12'(code);
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        sb.delete();
        win.delete();
        m_over = 0;
        step();
        step();
        check_eq("rst_ready", sample_ready, 0);
        check_eq("rst_temp", temperature, DEF);
        check_eq("rst_valid", temp_valid, 0);
        check_eq("rst_over", over_temp, 0);
        check_eq("rst_stale", sensor_stale, 0);
        reset = 1'b0;
        step();
        check_eq("ready_after_rst", sample_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        @(negedge clk);

        // Reset and initial fill
        do_reset();
        burst(800, N);
        idle(4);
        check_eq("fill_temp", temperature, 50);
        check_eq("fill_valid", temp_valid, 1);

        // Step response 50 -> 70
        burst(1120, N);
        idle(4);
        check_eq("step_temp", temperature, 70);

        // Alarm hysteresis
        alarm_hi_c = 8'd75;
        alarm_lo_c = 8'd70;
        burst(1280, N);
        idle(4);
        check_eq("alarm80_temp", temperature, 80);
        check_eq("alarm80_over", over_temp, 1);
        burst(1152, N);
        idle(4);
        check_eq("alarm72_temp", temperature, 72);
        check_eq("alarm72_over", over_temp, 1);
        burst(1120, N);
        idle(4);
        check_eq("alarm70_over", over_temp, 0);

        // Stale and recovery
        idle(4000);
        check_eq("not_stale_yet", sensor_stale, 0);
        waited = 0;
        while (!sensor_stale && waited < 300) begin
            step();
            waited++;
        end
        check_eq("stale_flag", sensor_stale, 1);
        check_eq("stale_over", over_temp, 1);
        check_eq("stale_temp", temperature, DEF);
        check_eq("stale_valid", temp_valid, 0);
        win.delete();
        m_over = 1;
        burst(800, 1);
        idle(1);
        check_eq("stale_drop", sensor_stale, 0);
        burst(800, N - 1);
        idle(4);
        check_eq("recover_temp", temperature, 50);
        check_eq("recover_valid", temp_valid, 1);

        // Calibration saturation
        cal_offset_x16 = 16'd400;
        burst(4095, N);
        idle(4);
        check_eq("sat_hi", temperature, 255);
        cal_offset_x16 = 16'hF830;
        burst(100, N);
        idle(4);
        check_eq("sat_lo", temperature, 0);
        cal_offset_x16 = 16'hFFF0;
        burst(800, N);
        idle(4);
        check_eq("offset_neg16", temperature, 49);

        // Reset mid-fill, then a gapped fill
        cal_offset_x16 = 16'd0;
        do_reset();
        burst(800, 5);
        do_reset();
        for (int i = 0; i < N; i++) begin
            burst(960, 1);
            idle(i % 2);
        end
        idle(4);
        check_eq("midfill_temp", temperature, 60);
        check_eq("midfill_valid", temp_valid, 1);
        check_eq("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
